// File: rtl/aspiradora_sensor_conditioner.sv
// aspiradora_sensor_conditioner
// Conditions the vacuum robot's raw switch inputs into clean requests for the
// control state machine: 2-flop synchronizers, per-input debouncers, a button
// press pulse, a timed evade (back-off) FSM and a minimum-dwell clean FSM.
// Cleaning and evading are never high together; evade always wins.
//
// Ports:
//   clk       in  system clock, rising edge
//   power_off in  asynchronous active-high reset / power-off request
//   btn_raw   in  raw bouncy power button
//   dirt_raw  in  raw dirt sensor (1 = dirt)
//   bump_raw  in  raw bumper switch (1 = contact)
//   on        out one-cycle pulse per debounced button press
//   cleaning  out clean request
//   evading   out evade request
module aspiradora_sensor_conditioner #(
  parameter int DEB_CYCLES   = 4,
  parameter int CLEAN_MIN    = 16,
  parameter int EVADE_CYCLES = 8,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic power_off,
  input  logic btn_raw,
  input  logic dirt_raw,
  input  logic bump_raw,
  output logic on,
  output logic cleaning,
  output logic evading
);

  typedef enum logic [1:0] {E_IDLE, E_BACKOFF, E_HOLD} e_state_t;
  typedef enum logic       {C_IDLE, C_ACTIVE}          c_state_t;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVADE_LOAD = CNT_W'(EVADE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAN_LOAD = CNT_W'(CLEAN_MIN - 1);

  // Bit 0 = button, bit 1 = dirt, bit 2 = bump.
  logic [2:0]       raw;
  logic [2:0]       s1_q, s1_d, s2_q, s2_d;
  logic [2:0]       db_q, db_d, db_prev_q, db_prev_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  e_state_t         e_state_q, e_state_d;
  c_state_t         c_state_q, c_state_d;
  logic [CNT_W-1:0] etimer_q, etimer_d;
  logic [CNT_W-1:0] ctimer_q, ctimer_d;
  logic             on_q, on_d;

  logic btn_rise, bump_rise, dirt_db, bump_db;

  assign raw = {bump_raw, dirt_raw, btn_raw};

  always_comb begin
    s1_d      = raw;
    s2_d      = s1_q;
    db_d      = db_q;
    db_prev_d = db_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        // This cycle is the DEB_CYCLES-th consecutive disagreement.
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Edges are taken from registered debounced values so both FSMs see
  // the same edge in the same cycle.
  assign btn_rise  = db_q[0] & ~db_prev_q[0];
  assign bump_rise = db_q[2] & ~db_prev_q[2];
  assign dirt_db   = db_q[1];
  assign bump_db   = db_q[2];

  always_comb begin
    on_d = btn_rise;

    e_state_d = e_state_q;
    etimer_d  = etimer_q;
    unique case (e_state_q)
      E_IDLE: begin
        if (bump_rise) begin
          e_state_d = E_BACKOFF;
          etimer_d  = EVADE_LOAD;
        end
      end
      E_BACKOFF: begin
        if (bump_rise) begin
          etimer_d = EVADE_LOAD;
        end else if (etimer_q == '0) begin
          e_state_d = bump_db ? E_HOLD : E_IDLE;
        end else begin
          etimer_d = etimer_q - 1'b1;
        end
      end
      E_HOLD: begin
        if (!bump_db) e_state_d = E_IDLE;
      end
      default: e_state_d = E_IDLE;
    endcase

    c_state_d = c_state_q;
    ctimer_d  = ctimer_q;
    unique case (c_state_q)
      C_IDLE: begin
        // Evade must be idle and not about to start, so the two outputs
        // can never overlap.
        if (dirt_db && (e_state_q == E_IDLE) && !bump_rise) begin
          c_state_d = C_ACTIVE;
          ctimer_d  = CLEAN_LOAD;
        end
      end
      C_ACTIVE: begin
        if (ctimer_q != '0) ctimer_d = ctimer_q - 1'b1;
        if (bump_rise) begin
          c_state_d = C_IDLE;
        end else if ((ctimer_q == '0) && !dirt_db) begin
          c_state_d = C_IDLE;
        end
      end
      default: c_state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge power_off) begin
    if (power_off) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      e_state_q <= E_IDLE;
      c_state_q <= C_IDLE;
      etimer_q  <= '0;
      ctimer_q  <= '0;
      on_q      <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      e_state_q <= e_state_d;
      c_state_q <= c_state_d;
      etimer_q  <= etimer_d;
      ctimer_q  <= ctimer_d;
      on_q      <= on_d;
    end
  end

  assign on       = on_q;
  assign cleaning = (c_state_q == C_ACTIVE);
  assign evading  = (e_state_q != E_IDLE);

endmodule

// File: doc/aspiradora_sensor_conditioner.md
Name: aspiradora_sensor_conditioner

Overview:
Front-end stage directly upstream of the vacuum-robot control state machine. Synchronizes and debounces the raw power button, dirt sensor and bumper switch. Produces the control FSM's inputs: `on` (single-cycle pulse), `cleaning` (level with minimum dwell) and `evading` (timed back-off). Guarantees `cleaning` and `evading` are never high together.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronized samples required before a debounced value changes (>=1)
CLEAN_MIN, 16, minimum cycles `cleaning` stays high once asserted (>=1)
EVADE_CYCLES, 8, minimum cycles `evading` stays high per bump event (>=1)
CNT_W, 8, width of debounce and dwell counters; all count parameters must fit in CNT_W bits

Ports:
clk  in  1  system clock, rising edge
power_off  in  1  asynchronous active-high reset; also the robot's power-off request
btn_raw  in  1  raw, bouncy, asynchronous power button
dirt_raw  in  1  raw, asynchronous dirt sensor; high means dirt detected
bump_raw  in  1  raw, asynchronous bumper switch; high means obstacle contact
on  out  1  one-cycle pulse on each debounced button press
cleaning  out  1  clean request to the control FSM
evading  out  1  evade request to the control FSM

Behaviour:
- Reset (power_off=1, asynchronous):
  - Synchronizers, debounced values, counters and timers all go to 0.
  - Both sub-FSMs go to IDLE.
  - on=0, cleaning=0, evading=0 immediately, without waiting for a clock edge.
  - Reset asserted mid-clean or mid-evade aborts the operation; no residual pulse or dwell after reset releases.
- Synchronizer: each raw input passes through a 2-flop synchronizer (sync value).
- Debouncer (one per input):
  - The counter clears whenever sync equals the debounced value.
  - Otherwise the counter increments each cycle.
  - When the count reaches DEB_CYCLES, the debounced value flips and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never reaches the debounced value.
- Latency: from the first clk edge sampling a stable raw change to the debounced change is DEB_CYCLES+2 cycles. Outputs are registered, so raw to output is DEB_CYCLES+3 cycles (7 at defaults).
- on: high for exactly one cycle after each rising edge of btn_db. No pulse on the falling edge or while held.
- Evade FSM (states E_IDLE, E_BACKOFF, E_HOLD); evading=1 in E_BACKOFF and E_HOLD:
  - E_IDLE: on a bump_db rising edge, go to E_BACKOFF and load etimer=EVADE_CYCLES-1.
  - E_BACKOFF:
    - etimer decrements to 0.
    - At etimer=0: if bump_db=0, go to E_IDLE; else go to E_HOLD.
    - A new bump_db rising edge in E_BACKOFF reloads etimer.
  - E_HOLD: when bump_db=0, go to E_IDLE.
  - Result: evading high for max(EVADE_CYCLES, cycles until bump releases).
- Clean FSM (states C_IDLE, C_ACTIVE); cleaning=1 only in C_ACTIVE:
  - C_IDLE: when dirt_db=1 and the evade FSM is in E_IDLE and no bump_db rising edge occurs this cycle, go to C_ACTIVE and load ctimer=CLEAN_MIN-1.
  - C_ACTIVE:
    - ctimer decrements, saturating at 0.
    - Go to C_IDLE when ctimer=0 and dirt_db=0.
    - Go to C_IDLE unconditionally on a bump_db rising edge (evade pre-empts clean).
- Mutual exclusion: on the edge where evading rises, cleaning falls. After evading falls, the clean FSM may re-enter C_ACTIVE on the next cycle if dirt_db=1, with the dwell restarted.
- Simultaneous dirt_db and bump_db rising edges: evade wins; cleaning stays 0.
- Counters never wrap; all timers saturate at 0.

Test Plan:
- Async reset: bump active with evading=1, assert power_off between edges -> evading=0 before the next edge. Release reset, hold bump_raw=0 -> evading stays 0.
- Button bounce: btn_raw toggles every 2 cycles for 12 cycles, then stays high 30 cycles -> exactly one `on` pulse, 7 cycles after stable high begins. Release -> no further pulse.
- Dirt glitch: dirt_raw high for 3 cycles -> cleaning never asserts.
- Dirt dwell: dirt_raw high for 5 cycles -> cleaning high for exactly 16 cycles. Dirt held 40 cycles -> cleaning stays high until 7 cycles after dirt_raw falls.
- Bump timing: bump_raw high for 6 cycles -> evading high for exactly 8 cycles. Bump held 30 cycles -> evading drops 7 cycles after bump_raw falls.
- Pre-emption: cleaning=1 with dirt held, bump occurs -> cleaning falls on the same edge evading rises. One cycle after evading falls, cleaning re-asserts, dwell 16. Dirt and bump rising on the same cycle -> only evading asserts.
